// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Sequences one ALU operation over the shared 8-bit bus
//            (load A, load B, execute, write back, capture flags).
//            Optional retired-op counter enabled by defining ALU_SEQ_OPCOUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [1:0]  i_src_a,
    input  logic [1:0]  i_src_b,
    input  logic [1:0]  i_dst,
    input  logic        i_flag_c,
    input  logic        i_flag_z,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_illegal,
    output logic [1:0]  o_reg_sel,
    output logic        o_reg_out_n,
    output logic        o_reg_in_n,
    output logic        o_load_a_n,
    output logic        o_load_b_n,
    output logic        o_alu_read_n,
    output logic        o_alu_subtract,
    output logic        o_alu_read_flags_n,
    output logic        o_flag_c,
    output logic        o_flag_z
`ifdef ALU_SEQ_OPCOUNT_EN
    ,
    output logic [15:0] o_op_count
`endif
);

    localparam logic [1:0] c_OP_ADD      = 2'b00;
    localparam logic [1:0] c_OP_SUB      = 2'b01;
    localparam logic [1:0] c_OP_CMP      = 2'b10;
    localparam logic [1:0] c_OP_ILL      = 2'b11;
    localparam logic [1:0] c_SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4,
        S_FLAGS  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_op, r_src_a, r_src_b, r_dst, r_cnt;
    logic [1:0] w_op, w_src_a, w_src_b, w_dst, w_cnt;

    logic       r_busy, r_done, r_illegal, r_reg_out_n, r_reg_in_n;
    logic       r_load_a_n, r_load_b_n, r_alu_read_n, r_alu_subtract, r_alu_read_flags_n;
    logic       r_flag_c, r_flag_z;
    logic [1:0] r_reg_sel;

    logic       w_busy, w_done, w_illegal, w_reg_out_n, w_reg_in_n;
    logic       w_load_a_n, w_load_b_n, w_alu_read_n, w_alu_subtract, w_alu_read_flags_n;
    logic [1:0] w_reg_sel;

    // Outputs are decoded from the state being entered so they are registered
    // and stable for the whole cycle spent in that state.
    always_comb begin
        w_next_state       = r_state;
        w_op               = r_op;
        w_src_a            = r_src_a;
        w_src_b            = r_src_b;
        w_dst              = r_dst;
        w_cnt              = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_op         = i_op;
                    w_src_a      = i_src_a;
                    w_src_b      = i_src_b;
                    w_dst        = i_dst;
                    w_next_state = (i_op == c_OP_ILL) ? S_DONE : S_LOAD_A;
                end
            end
            S_LOAD_A: w_next_state = S_LOAD_B;
            S_LOAD_B: begin
                w_next_state = S_EXEC;
                w_cnt        = 2'd0;
            end
            S_EXEC: begin
                if (r_cnt == c_SETTLE_LAST) begin
                    w_next_state = (r_op == c_OP_CMP) ? S_FLAGS : S_WRITE;
                end else begin
                    w_cnt = r_cnt + 2'd1;
                end
            end
            S_WRITE:  w_next_state = S_FLAGS;
            S_FLAGS:  w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase

        w_busy             = (w_next_state != S_IDLE);
        w_done             = (w_next_state == S_DONE);
        w_illegal          = (w_next_state == S_DONE) && (w_op == c_OP_ILL);
        w_reg_sel          = 2'b00;
        w_reg_out_n        = 1'b1;
        w_reg_in_n         = 1'b1;
        w_load_a_n         = 1'b1;
        w_load_b_n         = 1'b1;
        w_alu_read_n       = 1'b1;
        w_alu_subtract     = 1'b0;
        w_alu_read_flags_n = 1'b1;

        case (w_next_state)
            S_LOAD_A: begin
                w_reg_sel   = w_src_a;
                w_reg_out_n = 1'b0;
                w_load_a_n  = 1'b0;
            end
            S_LOAD_B: begin
                w_reg_sel   = w_src_b;
                w_reg_out_n = 1'b0;
                w_load_b_n  = 1'b0;
            end
            S_EXEC: begin
                w_alu_read_n   = 1'b0;
                w_alu_subtract = (w_op != c_OP_ADD);
            end
            S_WRITE: begin
                w_alu_read_n   = 1'b0;
                w_alu_subtract = (w_op == c_OP_SUB);
                w_reg_sel      = w_dst;
                w_reg_in_n     = 1'b0;
            end
            S_FLAGS:  w_alu_read_flags_n = 1'b0;
            default:  ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state            <= S_IDLE;
            r_op               <= 2'b00;
            r_src_a            <= 2'b00;
            r_src_b            <= 2'b00;
            r_dst              <= 2'b00;
            r_cnt              <= 2'b00;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_illegal          <= 1'b0;
            r_reg_sel          <= 2'b00;
            r_reg_out_n        <= 1'b1;
            r_reg_in_n         <= 1'b1;
            r_load_a_n         <= 1'b1;
            r_load_b_n         <= 1'b1;
            r_alu_read_n       <= 1'b1;
            r_alu_subtract     <= 1'b0;
            r_alu_read_flags_n <= 1'b1;
            r_flag_c           <= 1'b0;
            r_flag_z           <= 1'b0;
        end else begin
            r_state            <= w_next_state;
            r_op               <= w_op;
            r_src_a            <= w_src_a;
            r_src_b            <= w_src_b;
            r_dst              <= w_dst;
            r_cnt              <= w_cnt;
            r_busy             <= w_busy;
            r_done             <= w_done;
            r_illegal          <= w_illegal;
            r_reg_sel          <= w_reg_sel;
            r_reg_out_n        <= w_reg_out_n;
            r_reg_in_n         <= w_reg_in_n;
            r_load_a_n         <= w_load_a_n;
            r_load_b_n         <= w_load_b_n;
            r_alu_read_n       <= w_alu_read_n;
            r_alu_subtract     <= w_alu_subtract;
            r_alu_read_flags_n <= w_alu_read_flags_n;
            if (r_state == S_FLAGS) begin
                r_flag_c <= i_flag_c;
                r_flag_z <= i_flag_z;
            end
        end
    end

    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_illegal          = r_illegal;
    assign o_reg_sel          = r_reg_sel;
    assign o_reg_out_n        = r_reg_out_n;
    assign o_reg_in_n         = r_reg_in_n;
    assign o_load_a_n         = r_load_a_n;
    assign o_load_b_n         = r_load_b_n;
    assign o_alu_read_n       = r_alu_read_n;
    assign o_alu_subtract     = r_alu_subtract;
    assign o_alu_read_flags_n = r_alu_read_flags_n;
    assign o_flag_c           = r_flag_c;
    assign o_flag_z           = r_flag_z;

`ifdef ALU_SEQ_OPCOUNT_EN
    logic [15:0] r_op_count;

    // Counts retired legal ops; wraps naturally at 16 bits.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_op_count <= 16'h0000;
        end else if ((r_state == S_DONE) && (r_op != c_OP_ILL)) begin
            r_op_count <= r_op_count + 16'h0001;
        end
    end

    assign o_op_count = r_op_count;
`endif

endmodule
`default_nettype wire
